// File: rtl/mhd_pkg.sv
// rtl/mhd_pkg.sv - shared state encoding and width helper for the Hamming-distance monitor
package mhd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Bits needed to hold any count from 0 up to w inclusive
  function automatic int hd_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mhd_popcount.sv
// rtl/mhd_popcount.sv - combinational population count of a difference vector
module mhd_popcount
  import mhd_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CW    = hd_width(WIDTH)
) (
  input  logic [WIDTH-1:0] diff,
  output logic [CW-1:0]    count
);

  // Sum the set bits; CW is sized so an all-ones diff still fits
  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CW'(diff[i]);
    end
  end

endmodule

// File: rtl/mhd_stream_monitor.sv
// rtl/mhd_stream_monitor.sv - windowed Hamming-distance monitor with two-stage pipeline and stats
module mhd_stream_monitor
  import mhd_pkg::*;
#(
  parameter  int WIDTH = 64,
  parameter  int MHD   = 32,
  parameter  int CNT_W = 32,
  localparam int HD_W  = hd_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] win_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             res_valid,
  output logic [HD_W-1:0]  res_hd,
  output logic             res_f,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] viol_cnt,
  output logic [HD_W-1:0]  max_hd
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] win_len_q;
  logic [CNT_W-1:0] acc_cnt;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_diff;
  logic [HD_W-1:0]  pop;
  logic             start_acc;
  logic             accept;
  logic             last_accept;

  assign start_acc   = (state == ST_IDLE) && start;
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (acc_cnt == win_len_q - CNT_ONE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next state; DRAIN exits once stage 1 is empty because the final result
  // in stage 2 is folded into the stats on that same edge
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = (win_len == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (last_accept) state_nx = ST_DRAIN;
      ST_DRAIN: if (!s1_valid) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // State-decoded handshake and status outputs
  always_comb begin
    in_ready = (state == ST_RUN);
    busy     = (state != ST_IDLE);
    done     = (state == ST_DONE);
  end

  // Latch window length on start and count accepted pairs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_len_q <= '0;
      acc_cnt   <= '0;
    end else if (start_acc) begin
      win_len_q <= win_len;
      acc_cnt   <= '0;
    end else if (accept) begin
      acc_cnt <= acc_cnt + CNT_ONE;
    end
  end

  // Stage 1: capture the bitwise difference of an accepted pair
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_diff  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) s1_diff <= a ^ b;
    end
  end

  mhd_popcount #(.WIDTH(WIDTH), .CW(HD_W)) u_popcount (
    .diff  (s1_diff),
    .count (pop)
  );

  // Stage 2: register the distance and the violation flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_hd    <= '0;
      res_f     <= 1'b0;
    end else begin
      res_valid <= s1_valid;
      if (s1_valid) begin
        res_hd <= pop;
        res_f  <= (int'(pop) > MHD);
      end
    end
  end

  // Window statistics: cleared by an accepted start, saturating, held otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt <= '0;
      viol_cnt   <= '0;
      max_hd     <= '0;
    end else if (start_acc) begin
      sample_cnt <= '0;
      viol_cnt   <= '0;
      max_hd     <= '0;
    end else if (res_valid) begin
      if (sample_cnt != '1)      sample_cnt <= sample_cnt + CNT_ONE;
      if (res_f && viol_cnt != '1) viol_cnt <= viol_cnt + CNT_ONE;
      if (res_hd > max_hd)       max_hd     <= res_hd;
    end
  end

endmodule

// File: tb/tb_mhd_stream_monitor.sv
// tb/tb_mhd_stream_monitor.sv - randomized self-checking bench for mhd_stream_monitor
module tb_mhd_stream_monitor;

  localparam int WIDTH = 64;
  localparam int MHD   = 32;
  localparam int CNT_W = 32;
  localparam int HD_W  = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] win_len;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             res_valid;
  logic [HD_W-1:0]  res_hd;
  logic             res_f;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] viol_cnt;
  logic [HD_W-1:0]  max_hd;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [WIDTH-1:0] stim_a [64];
  logic [WIDTH-1:0] stim_b [64];

  int   acc_cyc [$];
  int   res_cyc [$];
  int   res_hd_log [$];
  logic res_f_log [$];
  int   done_cyc [$];
  int   done_sc [$];
  int   done_vc [$];
  int   done_mx [$];

  mhd_stream_monitor #(.WIDTH(WIDTH), .MHD(MHD), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .win_len    (win_len),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .res_valid  (res_valid),
    .res_hd     (res_hd),
    .res_f      (res_f),
    .busy       (busy),
    .done       (done),
    .sample_cnt (sample_cnt),
    .viol_cnt   (viol_cnt),
    .max_hd     (max_hd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Passive recorder: acceptances, results and done pulses with their cycle numbers
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) acc_cyc.push_back(cyc);
      if (res_valid) begin
        res_cyc.push_back(cyc);
        res_hd_log.push_back(int'(res_hd));
        res_f_log.push_back(res_f);
      end
      if (done) begin
        done_cyc.push_back(cyc);
        done_sc.push_back(int'(sample_cnt));
        done_vc.push_back(int'(viol_cnt));
        done_mx.push_back(int'(max_hd));
      end
    end
  end

  function automatic logic [WIDTH-1:0] rand_vec();
    return {$urandom, $urandom};
  endfunction

  // Returns base with exactly k distinct bits flipped
  function automatic logic [WIDTH-1:0] flip_bits(input logic [WIDTH-1:0] base, input int k);
    logic [WIDTH-1:0] m;
    m = '0;
    while ($countones(m) < k) m[$urandom_range(WIDTH-1, 0)] = 1'b1;
    return base ^ m;
  endfunction

  task automatic clear_log();
    acc_cyc.delete();
    res_cyc.delete();
    res_hd_log.delete();
    res_f_log.delete();
    done_cyc.delete();
    done_sc.delete();
    done_vc.delete();
    done_mx.delete();
  endtask

  task automatic do_start(input int len);
    start   = 1'b1;
    win_len = CNT_W'(len);
    @(posedge clk); #1;
    start   = 1'b0;
    win_len = CNT_W'($urandom_range(100, 1));
  endtask

  task automatic send_pairs(input int n, input bit gap, input int start_at);
    int sent  = 0;
    int guard = 0;
    bit phase = 1'b1;
    while (sent < n && guard < 200) begin
      in_valid = gap ? phase : 1'b1;
      phase    = ~phase;
      a        = in_valid ? stim_a[sent] : rand_vec();
      b        = in_valid ? stim_b[sent] : rand_vec();
      start    = (guard == start_at);
      win_len  = CNT_W'(1);
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    vectors++;
    if (sent != n) begin
      miscompares++;
      $display("FAIL accept_budget: accepted %0d pairs, required %0d", sent, n);
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cyc.size() == 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (done_cyc.size() == 0) begin
      miscompares++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    start    = 1'b0;
    win_len  = '0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({res_valid, res_f, busy, done, in_ready} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b required 00000", {res_valid, res_f, busy, done, in_ready});
    end
    vectors++;
    if ({res_hd, max_hd, sample_cnt, viol_cnt} !== '0) begin
      miscompares++;
      $display("FAIL reset_stats: hd=%0d max=%0d smp=%0d viol=%0d required all 0",
               res_hd, max_hd, sample_cnt, viol_cnt);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_window(input string name, input int len, input bit gap, input int start_at);
    int exp_hd;
    bit exp_f;
    int exp_viol = 0;
    int exp_max  = 0;
    clear_log();
    do_start(len);
    send_pairs(len, gap, start_at);
    wait_done(30);
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (res_cyc.size() != len || acc_cyc.size() != len) begin
      miscompares++;
      $display("FAIL %s result_count: results=%0d accepts=%0d required %0d",
               name, res_cyc.size(), acc_cyc.size(), len);
    end
    for (int i = 0; i < len && i < res_cyc.size() && i < acc_cyc.size(); i++) begin
      exp_hd = $countones(stim_a[i] ^ stim_b[i]);
      exp_f  = (exp_hd > MHD);
      exp_viol += int'(exp_f);
      if (exp_hd > exp_max) exp_max = exp_hd;
      vectors++;
      if (res_hd_log[i] != exp_hd || res_f_log[i] !== exp_f || res_cyc[i] != acc_cyc[i] + 2) begin
        miscompares++;
        $display("FAIL %s sample%0d: hd=%0d f=%0b lat=%0d required hd=%0d f=%0b lat=2",
                 name, i, res_hd_log[i], res_f_log[i], res_cyc[i] - acc_cyc[i], exp_hd, exp_f);
      end
    end
    vectors++;
    if (done_cyc.size() != 1 || res_cyc.size() == 0 || done_cyc[0] != res_cyc[res_cyc.size()-1] + 1) begin
      miscompares++;
      $display("FAIL %s done_timing: pulses=%0d required one pulse 1 cycle after last result",
               name, done_cyc.size());
    end
    vectors++;
    if (done_cyc.size() == 0 || done_sc[0] != len || done_vc[0] != exp_viol || done_mx[0] != exp_max) begin
      miscompares++;
      $display("FAIL %s done_stats: smp=%0d viol=%0d max=%0d required %0d %0d %0d", name,
               (done_sc.size() > 0) ? done_sc[0] : -1, (done_vc.size() > 0) ? done_vc[0] : -1,
               (done_mx.size() > 0) ? done_mx[0] : -1, len, exp_viol, exp_max);
    end
    vectors++;
    if (int'(sample_cnt) != len || int'(viol_cnt) != exp_viol || int'(max_hd) != exp_max || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s idle_hold: smp=%0d viol=%0d max=%0d busy=%0b required %0d %0d %0d 0",
               name, sample_cnt, viol_cnt, max_hd, busy, len, exp_viol, exp_max);
    end
  endtask

  task automatic test_zero_len();
    int c0;
    clear_log();
    start   = 1'b1;
    win_len = '0;
    c0      = cyc;
    @(posedge clk); #1;
    start   = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (done_cyc.size() != 1 || done_cyc[0] != c0 + 1) begin
      miscompares++;
      $display("FAIL zero_len_done: pulses=%0d at %0d required 1 at %0d",
               done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, c0 + 1);
    end
    vectors++;
    if (res_cyc.size() != 0 || sample_cnt !== '0 || viol_cnt !== '0 || max_hd !== '0) begin
      miscompares++;
      $display("FAIL zero_len_stats: results=%0d smp=%0d viol=%0d max=%0d required all 0",
               res_cyc.size(), sample_cnt, viol_cnt, max_hd);
    end
  endtask

  task automatic test_reset_mid_window();
    for (int i = 0; i < 5; i++) begin
      stim_a[i] = rand_vec();
      stim_b[i] = flip_bits(stim_a[i], 40);
    end
    clear_log();
    do_start(5);
    send_pairs(2, 1'b0, -1);
    rst = 1'b1;
    #1;
    vectors++;
    if ({res_valid, res_f, busy, done, in_ready} !== 5'b0 ||
        {res_hd, max_hd, sample_cnt, viol_cnt} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: rv=%0b f=%0b busy=%0b hd=%0d smp=%0d required all 0",
               res_valid, res_f, busy, res_hd, sample_cnt);
    end
    clear_log();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    vectors++;
    if (res_cyc.size() != 0 || done_cyc.size() != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_release: results=%0d dones=%0d busy=%0b required 0 0 0",
               res_cyc.size(), done_cyc.size(), busy);
    end
  endtask

  initial begin
    test_reset();

    for (int i = 0; i < 4; i++) begin
      stim_a[i] = '0;
      stim_b[i] = '0;
    end
    test_window("all_zero", 4, 1'b0, -1);

    stim_a[0] = '1;
    stim_b[0] = '0;
    test_window("all_ones", 1, 1'b0, -1);

    stim_a[0] = rand_vec();
    stim_b[0] = flip_bits(stim_a[0], MHD);
    stim_a[1] = rand_vec();
    stim_b[1] = flip_bits(stim_a[1], MHD + 1);
    test_window("boundary", 2, 1'b0, -1);

    test_zero_len();

    for (int i = 0; i < 8; i++) begin
      stim_a[i] = rand_vec();
      stim_b[i] = flip_bits(stim_a[i], $urandom_range(WIDTH, 0));
    end
    test_window("gaps_start", 8, 1'b1, 3);

    test_reset_mid_window();
    for (int i = 0; i < 5; i++) begin
      stim_a[i] = rand_vec();
      stim_b[i] = flip_bits(stim_a[i], $urandom_range(WIDTH, 0));
    end
    test_window("after_reset", 5, 1'b0, -1);

    for (int w = 0; w < 4; w++) begin
      int len = $urandom_range(30, 5);
      for (int i = 0; i < len; i++) begin
        stim_a[i] = rand_vec();
        stim_b[i] = flip_bits(stim_a[i], $urandom_range(MHD + 4, MHD - 4) % (WIDTH + 1));
        if ($urandom_range(3, 0) == 0) stim_b[i] = rand_vec();
      end
      test_window("random", len, w[0], -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
